// File: rtl/systolic_mac_cluster_pkg.sv
// Shared types and default sizing for the systolic MAC cluster.
// Optional saturation is selected by SYSTOLIC_CLUSTER_SAT_EN.
package systolic_pkg;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_VEC_LEN     = 16;
    localparam int DEF_MATRIX_SIZE = 5;
    localparam int DEF_OUT_SHIFT   = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_DONE
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_mac_cluster_if.sv
// Operand stream in, result row out, plus status.
// master = producer/consumer side, slave = cluster side.
interface systolic_mac_cluster_if
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
);

    logic                                        start;
    logic                                        in_valid;
    logic                                        in_ready;
    logic signed [DATA_WIDTH-1:0]                inputs;
    logic signed [DATA_WIDTH-1:0]                weights;
    logic signed [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] result_row;
    logic                                        out_valid;
    logic                                        out_ready;
    logic                                        busy;
    logic                                        sat_flag;

    modport master (
        output start, in_valid, inputs, weights, out_ready,
        input  in_ready, result_row, out_valid, busy, sat_flag
    );

    modport slave (
        input  start, in_valid, inputs, weights, out_ready,
        output in_ready, result_row, out_valid, busy, sat_flag
    );

endinterface

// File: rtl/systolic_mac_cluster_lane.sv
// One signed multiply-accumulate lane of the cluster.
// Clear wins over enable; product is kept at full precision.
module mac_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    assign prod  = a_i * b_i;
    assign acc_o = acc_q;

    // accumulate on enable, zero on clear or reset
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/systolic_mac_cluster.sv
// Row-of-dot-products MAC cluster: lanes share one operand stream.
// Define SYSTOLIC_CLUSTER_SAT_EN for saturating narrowing + sat_flag.
module systolic_mac_cluster
    import systolic_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int VEC_LEN     = DEF_VEC_LEN,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int OUT_SHIFT   = DEF_OUT_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_mac_cluster_if.slave bus
);

    localparam int SUM_W = ACC_WIDTH + $clog2(NUM_LANES);
    localparam int LN_W  = idx_w(NUM_LANES);
    localparam int EL_W  = idx_w(VEC_LEN);
    localparam int COL_W = idx_w(MATRIX_SIZE);

    state_e                                        state_q;
    logic [COL_W-1:0]                              col_q;
    logic [EL_W-1:0]                               elem_q;
    logic [LN_W-1:0]                               lane_q;
    logic signed [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] row_q;
    logic                                          out_valid_q;

    logic signed [ACC_WIDTH-1:0]  acc [NUM_LANES];
    logic                         accept;
    logic                         lane_clr;
    logic signed [SUM_W-1:0]      sum_d;
    logic signed [SUM_W-1:0]      shifted_d;
    logic signed [DATA_WIDTH-1:0] narrow_d;

    assign accept   = (state_q == S_LOAD) && bus.in_valid;
    assign lane_clr = ((state_q == S_IDLE) && bus.start)
                    || (state_q == S_REDUCE);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr_i (lane_clr),
            .en_i  (accept && (lane_q == LN_W'(i))),
            .a_i   (bus.inputs),
            .b_i   (bus.weights),
            .acc_o (acc[i])
        );
    end

    // adder tree over all lane accumulators, then output scaling
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum_d = sum_d + SUM_W'(acc[i]);
        end
        shifted_d = sum_d >>> OUT_SHIFT;
    end

`ifdef SYSTOLIC_CLUSTER_SAT_EN
    localparam logic signed [SUM_W-1:0] MAX_V =
        SUM_W'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    logic clip_d;
    logic sat_q;

    // clamp the scaled sum into the signed output range
    always_comb begin
        clip_d   = 1'b0;
        narrow_d = DATA_WIDTH'(shifted_d);
        if (shifted_d > MAX_V) begin
            clip_d   = 1'b1;
            narrow_d = DATA_WIDTH'(MAX_V);
        end else if (shifted_d < MIN_V) begin
            clip_d   = 1'b1;
            narrow_d = DATA_WIDTH'(MIN_V);
        end
    end

    // sticky clip indicator, cleared when a new row starts
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if ((state_q == S_IDLE) && bus.start) begin
            sat_q <= 1'b0;
        end else if ((state_q == S_REDUCE) && clip_d) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    // wrap: keep the low DATA_WIDTH bits
    always_comb begin
        narrow_d = DATA_WIDTH'(shifted_d);
    end

    assign bus.sat_flag = 1'b0;
`endif

    // row sequencer: load VEC_LEN pairs, reduce, repeat per column
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            elem_q      <= '0;
            lane_q      <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_LOAD;
                        col_q   <= '0;
                        elem_q  <= '0;
                        lane_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        elem_q <= elem_q + 1'b1;
                        lane_q <= (lane_q == LN_W'(NUM_LANES - 1))
                                ? '0 : lane_q + 1'b1;
                        if (elem_q == EL_W'(VEC_LEN - 1)) begin
                            state_q <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    row_q[col_q] <= narrow_d;
                    elem_q       <= '0;
                    lane_q       <= '0;
                    if (col_q == COL_W'(MATRIX_SIZE - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        col_q   <= col_q + 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.result_row = row_q;

endmodule

// File: tb/tb_systolic_mac_cluster.sv
// Randomised bench for systolic_mac_cluster against a dot-product model.
// Builds with or without SYSTOLIC_CLUSTER_SAT_EN.
module tb_systolic_mac_cluster;
    import systolic_pkg::*;

    localparam int DW   = 8;
    localparam int MS   = 5;
    localparam int VL   = 16;
    localparam int N    = MS * VL;
    localparam int SH_B = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    systolic_mac_cluster_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS)) bus ();
    systolic_mac_cluster_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS)) bus_b ();

    assign bus_b.start     = bus.start;
    assign bus_b.in_valid  = bus.in_valid;
    assign bus_b.inputs    = bus.inputs;
    assign bus_b.weights   = bus.weights;
    assign bus_b.out_ready = bus.out_ready;

    systolic_mac_cluster u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_mac_cluster #(
        .NUM_LANES (3),
        .OUT_SHIFT (SH_B)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int     total = 0;
    int     bad   = 0;
    int     av [N];
    int     bv [N];
    longint exp_a [MS];
    longint exp_b [MS];
    bit     sat_a;
    bit     sat_b;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint narrow(input longint s, input int sh,
                                      output bit clip);
        longint v;
        longint hi;
        v    = s >>> sh;
        hi   = (longint'(1) << (DW - 1)) - 1;
        clip = 1'b0;
`ifdef SYSTOLIC_CLUSTER_SAT_EN
        if (v > hi) begin
            clip = 1'b1;
            v    = hi;
        end else if (v < -hi - 1) begin
            clip = 1'b1;
            v    = -hi - 1;
        end
`else
        v = v & ((hi << 1) + 1);
        if (v > hi) v = v - ((hi + 1) << 1);
`endif
        return v;
    endfunction

    task automatic model();
        longint s;
        bit     cl;
        sat_a = 1'b0;
        sat_b = 1'b0;
        for (int c = 0; c < MS; c++) begin
            s = 0;
            for (int e = 0; e < VL; e++) begin
                s += longint'(av[c*VL+e]) * longint'(bv[c*VL+e]);
            end
            exp_a[c] = narrow(s, 0, cl);
            sat_a    = sat_a | cl;
            exp_b[c] = narrow(s, SH_B, cl);
            sat_b    = sat_b | cl;
        end
    endtask

    task automatic fill(input int mode, input int ca, input int cb);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                av[i] = ca;
                bv[i] = cb;
            end else begin
                av[i] = int'($urandom_range(0, 255)) - 128;
                bv[i] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    task automatic start_row();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic feed(input int gap, input int limit, output int low);
        int idx;
        int cyc;
        bit v;
        idx = 0;
        cyc = 0;
        low = 0;
        while (idx < limit && cyc < 4000) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = (cyc % 2 == 0);
            else               v = 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.inputs   = DW'(av[idx]);
            bus.weights  = DW'(bv[idx]);
            if (!bus.in_ready) low++;
            else if (v)        idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("feed_cnt", idx, limit);
    endtask

    task automatic run_row(input int gap, input string tag, input bit hold);
        int low;
        model();
        start_row();
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_sat_clr"}, bus.sat_flag, 0);
        feed(gap, N, low);
        chk({tag, "_rdy_low"}, low, MS - 1);
        chk({tag, "_ov_t1"}, bus.out_valid, 0);
        chk({tag, "_rdy_red"}, bus.in_ready, 0);
        @(negedge clk);
        chk({tag, "_ov_t2"}, bus.out_valid, 1);
        chk({tag, "_ov_b"}, bus_b.out_valid, 1);
        for (int c = 0; c < MS; c++) begin
            chk($sformatf("%s_a%0d", tag, c),
                longint'($signed(bus.result_row[c])), exp_a[c]);
            chk($sformatf("%s_b%0d", tag, c),
                longint'($signed(bus_b.result_row[c])), exp_b[c]);
        end
        chk({tag, "_sat_a"}, bus.sat_flag, longint'(sat_a));
        chk({tag, "_sat_b"}, bus_b.sat_flag, longint'(sat_b));
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                bus.start    = k[0];
                bus.in_valid = 1'b1;
                @(negedge clk);
                chk($sformatf("%s_hold_ov%0d", tag, k), bus.out_valid, 1);
                chk($sformatf("%s_hold_rdy%0d", tag, k), bus.in_ready, 0);
                chk($sformatf("%s_hold_row%0d", tag, k),
                    longint'($signed(bus.result_row[k % MS])),
                    exp_a[k % MS]);
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_rel_ov"}, bus.out_valid, 0);
        chk({tag, "_rel_busy"}, bus.busy, 0);
        @(negedge clk);
        chk({tag, "_idle_row0"},
            longint'($signed(bus.result_row[0])), exp_a[0]);
        chk({tag, "_idle_rowL"},
            longint'($signed(bus.result_row[MS-1])), exp_a[MS-1]);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"}, bus.out_valid, 0);
        chk({tag, "_rdy"}, bus.in_ready, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_sat"}, bus.sat_flag, 0);
        chk({tag, "_row"}, longint'(bus.result_row), 0);
        chk({tag, "_row_b"}, longint'(bus_b.result_row), 0);
    endtask

    initial begin
        int low;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inputs    = '0;
        bus.weights   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        fill(0, 1, 1);
        run_row(0, "ones", 1'b0);
        fill(0, 1, 1);
        run_row(1, "ones_tog", 1'b0);
        fill(0, 127, 127);
        run_row(0, "pos_max", 1'b1);
        fill(0, -128, 127);
        run_row(2, "neg_max", 1'b0);
        for (int r = 0; r < 4; r++) begin
            fill(1, 0, 0);
            run_row(2, $sformatf("rnd%0d", r), 1'b0);
        end

        fill(0, 5, 7);
        start_row();
        feed(0, 2 * VL + 7, low);
        chk("mid_rdy_low", low, 2);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_rst");
        rst = 1'b0;
        fill(0, 2, 3);
        run_row(0, "after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_mac_cluster.md
SYSTOLIC_MAC_CLUSTER -- requirements
Module: systolic_mac_cluster

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of parallel MAC lanes (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: signed operand and result width.
REQ-003 SHALL have parameter ACC_WIDTH, default 24: signed per-lane accumulator width.
REQ-004 SHALL have parameter VEC_LEN, default 16: operand pairs per dot product (>=1).
REQ-005 SHALL have parameter MATRIX_SIZE, default 5: dot products per result row.
REQ-006 SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift applied before narrowing.
REQ-007 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, synchronous, active-high reset). One clock; reset is synchronous and active-high.
REQ-008 SHALL have ports `start` (in, 1, begins a row in IDLE), `in_valid` (in, 1), `in_ready` (out, 1), `inputs` (in, DATA_WIDTH, signed) and `weights` (in, DATA_WIDTH, signed).
REQ-009 SHALL have ports `result_row` (out, MATRIX_SIZE x DATA_WIDTH, signed), `out_valid` (out, 1), `out_ready` (in, 1), `busy` (out, 1, state != IDLE) and `sat_flag` (out, 1, sticky saturation indicator for the row).

Function
REQ-010 SHALL implement the FSM IDLE -> LOAD -> REDUCE -> (LOAD | DONE) -> IDLE.
REQ-011 In IDLE, `start`=1 SHALL move to LOAD and clear col, elem_cnt, lane accumulators and sat_flag.
REQ-012 `start` SHALL be ignored outside IDLE.
REQ-013 `in_ready` SHALL be 1 only in LOAD; a pair is accepted when `in_valid` && `in_ready`.
REQ-014 An accepted pair SHALL go to lane (elem_cnt mod NUM_LANES), which adds the full-precision product inputs*weights to its accumulator; elem_cnt then increments.
REQ-015 Accepting the pair with elem_cnt==VEC_LEN-1 SHALL move to REDUCE on the next cycle.
REQ-016 REDUCE SHALL take one cycle: sum all lanes at width ACC_WIDTH+clog2(NUM_LANES), apply `>>>` OUT_SHIFT, narrow to DATA_WIDTH per REQ-023/024, write result_row[col], clear the lanes and elem_cnt.
REQ-017 From REDUCE, col<MATRIX_SIZE-1 SHALL increment col and go to LOAD; otherwise the FSM SHALL go to DONE.
REQ-018 DONE SHALL hold `out_valid`=1 with `result_row` stable until `out_ready`=1, then go to IDLE.
REQ-019 Latency: last pair of a row accepted in cycle t -> REDUCE in t+1 -> `out_valid`=1 in t+2.
REQ-020 `result_row` SHALL hold its value through IDLE until the next REDUCE write.
REQ-021 `in_valid` gaps in LOAD SHALL stall without changing any accumulator.

Reset
REQ-022 `rst` SHALL force IDLE in any state and zero `result_row`, `out_valid`, `in_ready`, `busy`, `sat_flag`, all accumulators and counters; a partial row is discarded.

Configuration
REQ-023 With SYSTOLIC_CLUSTER_SAT_EN defined, narrowing SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; any clipped value sets `sat_flag` until the next start or `rst`.
REQ-024 Without SYSTOLIC_CLUSTER_SAT_EN, narrowing SHALL truncate to the low DATA_WIDTH bits (wrap), and `sat_flag` SHALL be tied 0.

Structure
REQ-025 Package systolic_pkg SHALL hold the FSM state enum and the default width constants.
REQ-026 Sub-module mac_lane SHALL contain one signed multiply-accumulate register with enable and clear; systolic_mac_cluster instantiates NUM_LANES of them.

Verification (defaults unless noted)
REQ-027 start, then 80 pairs (1,1) with in_valid held -> result_row all 16, out_valid at t+2 of the 80th pair, sat_flag 0.
REQ-028 Same stimulus with in_valid toggling every cycle -> identical result_row = 16 x5, in_ready 1 throughout LOAD.
REQ-029 80 pairs (127,127) -> SAT_EN: all 127, sat_flag 1; no SAT_EN: all 16 (258064 mod 256), sat_flag 0.
REQ-030 80 pairs (-128,127) with SAT_EN -> all -128, sat_flag 1; OUT_SHIFT=12 gives -64 each (sum -260096 >>> 12 = -64, in range), sat_flag 0.
REQ-031 In DONE, hold out_ready 0 for 10 cycles while pulsing start and in_valid -> result_row stable, in_ready 0, no state change; out_ready=1 -> IDLE next cycle.
REQ-032 rst asserted after 7 pairs of col 2 -> next cycle IDLE with all outputs 0; a fresh row of (2,3) pairs -> all 96.
